cc_miss_req_unit: RTL
=====================

CC_MISS_REQ_UNIT -- requirements
Module: cc_miss_req_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter FIFO_DEPTH, default 4, number of outstanding misses; power of two, minimum 2.
REQ-003 Parameter AR_ID, default 4'd0, constant driven on mem_arid_o.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 miss_req_valid_i  in  1  tag-compare stage presents a miss.
REQ-007 miss_req_addr_i  in  32  byte address of the missing access.
REQ-008 miss_req_ready_o  out  1  miss accepted when high with valid.
REQ-009 mem_arid_o  out  4  AXI AR id, equal to AR_ID.
REQ-010 mem_araddr_o  out  32  AXI AR address.
REQ-011 mem_arlen_o  out  4  AXI AR length, constant 4'd7 (8 beats).
REQ-012 mem_arsize_o  out  3  AXI AR size, constant 3'b011 (8 bytes).
REQ-013 mem_arburst_o  out  2  AXI AR burst type, per REQ-030.
REQ-014 mem_arvalid_o  out  1  AXI AR valid.
REQ-015 mem_arready_i  in  1  AXI AR ready.
REQ-016 miss_addr_fifo_empty_o  out  1  miss address FIFO empty.
REQ-017 miss_addr_fifo_rdata_o  out  32  head entry, show-ahead.
REQ-018 miss_addr_fifo_rden_i  in  1  pop request from data fill unit.
REQ-019 outstanding_cnt_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-020 FSM states IDLE and REQ SHALL be encoded in a register; IDLE after reset.
REQ-021 miss_req_ready_o SHALL be (state==IDLE) and FIFO not full, combinationally.
REQ-022 On valid&&ready at edge N: SHALL register AR address, push entry into FIFO, move to REQ; at N+1 mem_arvalid_o=1, miss_addr_fifo_empty_o=0, outstanding_cnt_o incremented.
REQ-023 In REQ, mem_arvalid_o SHALL be 1 and mem_araddr_o/arburst SHALL hold stable until mem_arready_i=1; on that edge return to IDLE.
REQ-024 mem_arvalid_o SHALL be 0 in IDLE; maximum AR issue rate is one per two cycles.
REQ-025 FIFO SHALL be show-ahead: miss_addr_fifo_rdata_o equals oldest entry whenever not empty; value when empty is don't-care.
REQ-026 rden with FIFO non-empty SHALL pop at that edge; rden while empty SHALL be ignored (no pointer change, no underflow).
REQ-027 Simultaneous push and pop with FIFO non-empty: occupancy unchanged, both pointers advance.
REQ-028 Push and pop in same cycle while empty: push takes effect, pop ignored; occupancy becomes 1.
REQ-029 FIFO full: ready low, no push; a pop that cycle frees one slot, ready high next cycle; pointers wrap modulo FIFO_DEPTH.
REQ-030 mem_araddr_o and the pushed FIFO entry SHALL be derived from miss_req_addr_i per Configuration.

Reset
REQ-031 Reset SHALL clear state to IDLE, FIFO pointers and occupancy to 0; outputs: mem_arvalid_o=0, miss_req_ready_o=1, miss_addr_fifo_empty_o=1, outstanding_cnt_o=0, mem_araddr_o=0.
REQ-032 Reset asserted mid-REQ SHALL drop mem_arvalid_o immediately (asynchronously) and discard all queued entries.

Configuration
REQ-033 Macro CC_CRITICAL_WORD_FIRST_EN defined: mem_arburst_o=2'b10 (WRAP); mem_araddr_o and FIFO entry = {addr[31:3],3'b000}.
REQ-034 Macro undefined: mem_arburst_o=2'b01 (INCR); mem_araddr_o and FIFO entry = {addr[31:6],6'b0}, so fill offset is always 0.

Verification
REQ-035 Single miss addr 0x0001_2348, arready high at N+1 -> arvalid one cycle, araddr 0x0001_2348 (macro on) / 0x0001_2340 (off), arlen 7, FIFO rdata same, cnt 1.
REQ-036 arready held low 5 cycles -> arvalid and araddr stable 6 cycles, ready low throughout, returns IDLE after handshake.
REQ-037 Four back-to-back misses, no pops (DEPTH 4) -> cnt 4, ready low; fifth miss stalls until one pop, accepted the cycle after pop.
REQ-038 Pops in order return addresses in push order; rden while empty -> cnt stays 0, empty stays 1.
REQ-039 Push and pop same edge with cnt 2 -> cnt stays 2, head advances.
REQ-040 Reset asserted during REQ with cnt 3 -> arvalid 0 immediately, cnt 0, empty 1, ready 1 after release.

Source files
------------

// File: rtl/cc_miss_req_unit.sv
// cc_miss_req_unit
// Turns cache misses from the tag-compare stage into AXI AR bursts
// (8 beats x 8 bytes). It also queues each miss line address in a small
// show-ahead FIFO. The data fill unit reads that FIFO to learn where the
// returning data belongs.
//
// Optional feature macro: CC_CRITICAL_WORD_FIRST_EN
//   defined   : WRAP burst, request aligned to the 8-byte word
//               (the critical word returns first)
//   undefined : INCR burst, request aligned to the 64-byte line
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   miss_req_valid_i/addr_i  miss presented by the tag-compare stage
//   miss_req_ready_o         miss accepted when high together with valid
//   mem_ar*                  AXI read-address channel
//   miss_addr_fifo_*         show-ahead FIFO of outstanding miss addresses
//   outstanding_cnt_o        FIFO occupancy
module cc_miss_req_unit #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] AR_ID      = 4'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req_valid_i,
  input  logic [31:0]                   miss_req_addr_i,
  output logic                          miss_req_ready_o,
  output logic [3:0]                    mem_arid_o,
  output logic [31:0]                   mem_araddr_o,
  output logic [3:0]                    mem_arlen_o,
  output logic [2:0]                    mem_arsize_o,
  output logic [1:0]                    mem_arburst_o,
  output logic                          mem_arvalid_o,
  input  logic                          mem_arready_i,
  output logic                          miss_addr_fifo_empty_o,
  output logic [31:0]                   miss_addr_fifo_rdata_o,
  input  logic                          miss_addr_fifo_rden_i,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef CC_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0]  BURST     = 2'b10;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFF8;
`else
  localparam logic [1:0]  BURST     = 2'b01;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFC0;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_arvalid;
  logic [31:0]     r_araddr;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     w_line_addr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  // The same aligned address goes to the AR channel and to the FIFO.
  // This keeps the fill unit and the memory request consistent.
  assign w_line_addr = miss_req_addr_i & ADDR_MASK;
  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty     = (r_cnt == '0);

  // A new miss is taken only while no AR is pending and a slot is free.
  // The ready path checks "not full" before any pop in the same cycle.
  // So a slot freed by a pop becomes usable on the next cycle.
  assign miss_req_ready_o = (r_state == ST_IDLE) && !w_full;
  assign w_push           = miss_req_valid_i && miss_req_ready_o;
  // A pop while empty is dropped. The pointers cannot underflow.
  assign w_pop            = miss_addr_fifo_rden_i && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state   <= ST_REQ;
            r_arvalid <= 1'b1;
            r_araddr  <= w_line_addr;
          end
        end
        ST_REQ: begin
          if (mem_arready_i) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      // The pointers are log2(depth) bits wide.
      // They therefore wrap modulo the depth on their own.
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage is data only. Occupancy tracks validity, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_line_addr;
  end

  assign mem_arid_o             = AR_ID;
  assign mem_araddr_o           = r_araddr;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'b011;
  assign mem_arburst_o          = BURST;
  assign mem_arvalid_o          = r_arvalid;
  assign miss_addr_fifo_empty_o = w_empty;
  assign miss_addr_fifo_rdata_o = r_mem[r_rptr];
  assign outstanding_cnt_o      = r_cnt;

endmodule
